bit_sequencer: RTL and testbench

Bit-cycle scheduler for the bit-serial datapath. It sits between the instruction control FSM and the shift registers/ALU. Once per accepted start it produces the per-bit shift enables, the bit index, first/last-bit flags and the carry seed. It repeats the DATA_W-bit pass a programmable number of times, which is used for multi-position SLLI/SRLI, and raises a one-cycle done, the FSM's bit_done.

---
 rtl/bit_sequencer.sv | 121 ++++++++++++
 tb/tb_bit_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bit_sequencer.sv
// Bit-cycle scheduler for the bit-serial datapath: emits per-bit shift enables, bit index,
// first/last flags and carry seed over N passes. Optional stall counter: BITSEQ_STALL_CNT_EN.
module bit_sequencer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 3,
    parameter int PASS_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_sub,
    input  logic [PASS_W-1:0] passes,
    input  logic              hold,
    input  logic              abort,
    output logic              busy,
    output logic              shift_en,
    output logic [CNT_W-1:0]  bit_idx,
    output logic              first_bit,
    output logic              last_bit,
    output logic              carry_seed,
    output logic              pass_done,
`ifdef BITSEQ_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    idx_q, idx_nxt;
    logic [PASS_W-1:0]   pass_q, pass_nxt;
    logic                sub_q, sub_nxt;
    logic                first_q, first_nxt;
    logic                at_last;

    assign at_last = (idx_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx_q   <= '0;
            pass_q  <= '0;
            sub_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx_q   <= idx_nxt;
            pass_q  <= pass_nxt;
            sub_q   <= sub_nxt;
            first_q <= first_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        pass_nxt  = pass_q;
        sub_nxt   = sub_q;
        first_nxt = first_q;
        if (abort) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            pass_nxt  = '0;
            first_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sub_nxt   = op_sub;
                        pass_nxt  = passes;
                        idx_nxt   = '0;
                        first_nxt = 1'b1;
                        state_nxt = (passes == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (!hold) begin
                        if (!at_last) begin
                            idx_nxt = idx_q + CNT_W'(1);
                        end else if (pass_q > PASS_W'(1)) begin
                            idx_nxt   = '0;
                            pass_nxt  = pass_q - PASS_W'(1);
                            first_nxt = 1'b0;
                        end else begin
                            state_nxt = DONE;
                            idx_nxt   = '0;
                            pass_nxt  = '0;
                            first_nxt = 1'b0;
                        end
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Every per-bit strobe is qualified by shift_en so a stall masks them all.
    assign busy       = (state != IDLE);
    assign shift_en   = (state == RUN) && !hold;
    assign bit_idx    = idx_q;
    assign first_bit  = shift_en && first_q && (idx_q == '0);
    assign last_bit   = shift_en && at_last;
    assign carry_seed = first_bit && sub_q;
    assign pass_done  = last_bit && (pass_q > PASS_W'(1));
    assign done       = (state == DONE);

`ifdef BITSEQ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start && !abort) begin
            stall_cnt <= '0;
        end else if (state == RUN && hold && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bit_sequencer.sv
// Scoreboard bench for bit_sequencer: a step-count reference model queues expected outputs
// per cycle, a negedge monitor pops and compares them.
module tb_bit_sequencer;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst, start, op_sub, hold, abort;
    logic [2:0] passes;
    logic       busy, shift_en, first_bit, last_bit, carry_seed, pass_done, done;
    logic [2:0] bit_idx;
`ifdef BITSEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    bit_sequencer #(.DATA_W(8), .CNT_W(3), .PASS_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .passes(passes),
        .hold(hold), .abort(abort), .busy(busy), .shift_en(shift_en),
        .bit_idx(bit_idx), .first_bit(first_bit), .last_bit(last_bit),
        .carry_seed(carry_seed), .pass_done(pass_done),
`ifdef BITSEQ_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .done(done)
    );

    typedef struct packed {
        logic        busy, sh, fb, lb, cs, pd, dn;
        logic        chk;
        logic [2:0]  idx;
        logic [15:0] stall;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model: a sequence is just a step count k out of total = passes*W.
    bit  m_valid = 0, m_run = 0, m_fin = 0, m_sub = 0, m_clean = 0;
    int  m_k = 0, m_total = 0, m_stall = 0;

    function automatic exp_t model_out(input logic h);
        exp_t e;
        int   b;
        b       = m_k % W;
        e.sh    = m_run && !h;
        e.fb    = e.sh && (m_k == 0);
        e.lb    = e.sh && (b == W - 1);
        e.pd    = e.lb && ((m_k / W) < (m_total / W - 1));
        e.cs    = e.fb && m_sub;
        e.dn    = m_fin;
        e.busy  = m_run || m_fin;
        e.chk   = m_run || m_clean;
        e.idx   = m_run ? 3'(b) : 3'd0;
        e.stall = 16'(m_stall);
        return e;
    endfunction

    task automatic step(input logic i_rst, i_start, i_abort, i_hold, i_op,
                        input logic [2:0] i_pass);
        rst = i_rst; start = i_start; abort = i_abort; hold = i_hold;
        op_sub = i_op; passes = i_pass;
        if (m_valid) q.push_back(model_out(i_hold));
        @(posedge clk);
        if (i_rst) begin
            m_valid = 1; m_run = 0; m_fin = 0; m_k = 0; m_sub = 0;
            m_clean = 1; m_stall = 0;
        end else begin
            if (m_run && i_hold && m_stall < 65535) m_stall++;
            if (i_abort) begin
                m_run = 0; m_fin = 0; m_clean = 1;
            end else if (m_fin) begin
                m_fin = 0;
            end else if (m_run) begin
                if (!i_hold) begin
                    m_k++;
                    if (m_k == m_total) begin m_run = 0; m_fin = 1; end
                end
            end else if (i_start) begin
                m_sub = i_op; m_clean = 0; m_stall = 0; m_k = 0;
                m_total = int'(i_pass) * W;
                if (i_pass == 3'd0) m_fin = 1; else m_run = 1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 3'd0);
    endtask

    always @(negedge clk) begin
        exp_t e, a;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = '{busy: busy, sh: shift_en, fb: first_bit, lb: last_bit, cs: carry_seed,
                  pd: pass_done, dn: done, chk: e.chk, idx: bit_idx, stall: 16'd0};
`ifdef BITSEQ_STALL_CNT_EN
            a.stall = stall_cnt;
`else
            e.stall = 16'd0;
`endif
            if (!e.chk) begin a.idx = 3'd0; e.idx = 3'd0; end
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d got busy%b sh%b fb%b lb%b cs%b pd%b dn%b idx%0d st%0d want busy%b sh%b fb%b lb%b cs%b pd%b dn%b idx%0d st%0d",
                         cyc, a.busy, a.sh, a.fb, a.lb, a.cs, a.pd, a.dn, a.idx, a.stall,
                         e.busy, e.sh, e.fb, e.lb, e.cs, e.pd, e.dn, e.idx, e.stall);
            end
        end
    end

    initial begin
        rst = 1; start = 0; abort = 0; hold = 0; op_sub = 0; passes = 3'd0;
        @(posedge clk); #1;
        step(1, 0, 0, 0, 0, 3'd0);
        step(1, 0, 0, 0, 0, 3'd0);
        idle(2);
        // single pass, then subtract seed, then plain add
        step(0, 1, 0, 0, 0, 3'd1); idle(11);
        step(0, 1, 0, 0, 1, 3'd1); idle(10);
        step(0, 1, 0, 0, 0, 3'd1); idle(10);
        // three passes
        step(0, 1, 0, 0, 1, 3'd3); idle(27);
        // hold three cycles at bit 4
        step(0, 1, 0, 0, 0, 3'd1); idle(4);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 3'd0);
        idle(7);
        // abort at bit 5
        step(0, 1, 0, 0, 0, 3'd2); idle(5);
        step(0, 0, 1, 0, 0, 3'd0); idle(3);
        // zero passes
        step(0, 1, 0, 0, 1, 3'd0); idle(3);
        // start held high through RUN and DONE
        for (int i = 0; i < 22; i++) step(0, 1, 0, 0, 1, 3'd1);
        idle(10);
        // start with abort in IDLE
        step(0, 1, 1, 0, 0, 3'd2); idle(3);
        // reset at bit 6
        step(0, 1, 0, 0, 0, 3'd1); idle(6);
        step(1, 0, 0, 0, 0, 3'd0); idle(3);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 59) == 0), ($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end
        idle(2);
        @(negedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
